// File: rtl/simple_ctrl_seq.sv
// simple_ctrl_seq: SIMPLE CPU control unit -- run/stop/halt FSM, 5-phase sequencer with memory
// wait states on P1/P4, and instruction decode. Define SIMPLE_CTRL_STEP_EN to add the single-step input.
module simple_ctrl_seq #(
  parameter int MEM_WAIT = 0,
  parameter int PHASE_W  = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exec,
`ifdef SIMPLE_CTRL_STEP_EN
  input  logic               step,
`endif
  input  logic [15:0]        instruction,
  input  logic [3:0]         SZCV,
  output logic [PHASE_W-1:0] phase,
  output logic               running,
  output logic               halted,
  output logic               updateInstruction,
  output logic               updateSZCV,
  output logic               updatePC,
  output logic               addressSrc,
  output logic               regDst,
  output logic               ALUSrcAR,
  output logic               ALUSrcBR,
  output logic               DRSrc,
  output logic               outputEnable,
  output logic               inputEnable,
  output logic               memWrite,
  output logic               branch,
  output logic               regWrite,
  output logic               memToReg,
  output logic [3:0]         ALUOp
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED} state_e;

  localparam logic [PHASE_W-1:0] P1        = PHASE_W'(1);
  localparam logic [3:0]         WAIT_LAST = 4'(MEM_WAIT);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [3:0]           wait_q, wait_d;
  logic                 stop_q, stop_d;
  logic                 single_q, single_d;

  logic [1:0] cls;
  logic [3:0] op;
  logic [2:0] sub;
  logic [2:0] cond;
  logic       flag_s, flag_z, flag_v;

  logic is_alu, is_shift, is_in, is_out, is_halt;
  logic is_ld, is_st, is_li, is_b, is_bcc;
  logic br_taken;
  logic ph1, ph2, ph3, ph4, ph5;
  logic phase_last;
  logic run_now;

  // The carry flag and the low instruction nibble are not consumed by this unit.
  logic unused_ok;
  assign unused_ok = ^{instruction[3:0], SZCV[1]};

  assign cls    = instruction[15:14];
  assign op     = instruction[7:4];
  assign sub    = instruction[13:11];
  assign cond   = instruction[10:8];
  assign flag_s = SZCV[3];
  assign flag_z = SZCV[2];
  assign flag_v = SZCV[0];

  assign is_alu   = (cls == 2'b11) && !op[3];
  assign is_shift = (cls == 2'b11) && (op[3:2] == 2'b10);
  assign is_in    = (cls == 2'b11) && (op == 4'b1100);
  assign is_out   = (cls == 2'b11) && (op == 4'b1101);
  assign is_halt  = (cls == 2'b11) && (op == 4'b1111);
  assign is_ld    = (cls == 2'b00);
  assign is_st    = (cls == 2'b01);
  assign is_li    = (cls == 2'b10) && (sub == 3'b000);
  assign is_b     = (cls == 2'b10) && (sub == 3'b100);
  assign is_bcc   = (cls == 2'b10) && (sub == 3'b111);

  always_comb begin
    br_taken = 1'b0;
    if (is_b) begin
      br_taken = 1'b1;
    end else if (is_bcc) begin
      case (cond)
        3'b000:  br_taken = flag_z;
        3'b001:  br_taken = flag_s ^ flag_v;
        3'b010:  br_taken = flag_z | (flag_s ^ flag_v);
        3'b011:  br_taken = !flag_z;
        default: br_taken = 1'b0;
      endcase
    end
  end

  assign ph1 = phase_q[0];
  assign ph2 = phase_q[1];
  assign ph3 = phase_q[2];
  assign ph4 = phase_q[3];
  assign ph5 = phase_q[4];

  // Only the memory phases P1 and P4 stretch; every other phase is a single cycle.
  assign phase_last = (ph1 || ph4) ? (wait_q == WAIT_LAST) : 1'b1;
  assign run_now    = (state_q == ST_RUN);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    wait_d   = wait_q;
    stop_d   = stop_q;
    single_d = single_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (exec) begin
          state_d  = ST_RUN;
          phase_d  = P1;
          wait_d   = '0;
          stop_d   = 1'b0;
          single_d = 1'b0;
        end
`ifdef SIMPLE_CTRL_STEP_EN
        else if (step) begin
          state_d  = ST_RUN;
          phase_d  = P1;
          wait_d   = '0;
          stop_d   = 1'b0;
          single_d = 1'b1;
        end
`endif
      end
      ST_RUN: begin
        stop_d = stop_q | exec;
        if (!phase_last) begin
          wait_d = wait_q + 4'd1;
        end else begin
          wait_d = '0;
          if (ph5) begin
            // Instruction boundary: HALT outranks a pending stop; exec seen on exit is dropped.
            if (is_halt) begin
              state_d  = ST_HALTED;
              phase_d  = '0;
              stop_d   = 1'b0;
              single_d = 1'b0;
            end else if (stop_q || single_q) begin
              state_d  = ST_IDLE;
              phase_d  = '0;
              stop_d   = 1'b0;
              single_d = 1'b0;
            end else begin
              phase_d = P1;
            end
          end else begin
            phase_d = phase_q << 1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        phase_d  = '0;
        wait_d   = '0;
        stop_d   = 1'b0;
        single_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      wait_q   <= '0;
      stop_q   <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      wait_q   <= wait_d;
      stop_q   <= stop_d;
      single_q <= single_d;
    end
  end

  assign phase   = phase_q;
  assign running = run_now;
  assign halted  = (state_q == ST_HALTED);

  always_comb begin
    updateInstruction = 1'b0;
    updateSZCV        = 1'b0;
    updatePC          = 1'b0;
    addressSrc        = 1'b0;
    regDst            = 1'b0;
    ALUSrcAR          = 1'b0;
    ALUSrcBR          = 1'b0;
    DRSrc             = 1'b0;
    outputEnable      = 1'b0;
    inputEnable       = 1'b0;
    memWrite          = 1'b0;
    branch            = 1'b0;
    regWrite          = 1'b0;
    memToReg          = 1'b0;
    ALUOp             = 4'b0000;
    if (run_now) begin
      updateInstruction = ph1 && phase_last;
      updateSZCV        = ph3;
      updatePC          = ph5;
      addressSrc        = ph4;
      regDst            = ph2 && is_ld;
      ALUSrcAR          = ph3 && (cls == 2'b11);
      ALUSrcBR          = ph3 && (cls != 2'b10);
      DRSrc             = ph3 && (cls == 2'b11) && op[3];
      outputEnable      = ph3 && is_out;
      inputEnable       = ph4 && is_in;
      memWrite          = ph4 && is_st;
      branch            = ph4 && phase_last && br_taken;
      regWrite          = ph5 && (is_alu || is_shift || is_in || is_ld || is_li);
      memToReg          = ph5 && (is_ld || is_in);
      if (cls == 2'b11) begin
        ALUOp = op;
      end else if (is_li) begin
        ALUOp = 4'b0110;
      end
    end
  end

endmodule

// File: tb/tb_simple_ctrl_seq.sv
// Bench for simple_ctrl_seq: two instances (MEM_WAIT 0 and 2) share stimulus; a cycle-index model
// predicts every output cycle and a scoreboard monitor compares on the falling edge.
module tb_simple_ctrl_seq;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  localparam int K_ALU = 0, K_SHIFT = 1, K_IN = 2, K_OUT = 3, K_HALT = 4, K_LD = 5;
  localparam int K_ST = 6, K_LI = 7, K_B = 8, K_BCC = 9, K_UNDEF = 10;

  localparam logic [15:0] TABLE [16] = '{
    16'hC000, 16'hC010, 16'hC080, 16'hC0C0, 16'hC0D0, 16'hC0E0, 16'hC0F0, 16'h0000,
    16'h4000, 16'h8000, 16'hA000, 16'hB800, 16'hB900, 16'hBA00, 16'hBB00, 16'h9000
  };

  logic        clock = 1'b0;
  logic        reset;
  logic        exec;
  logic [15:0] instruction;
  logic [3:0]  SZCV;

  wire [24:0] act_w [2];

  int total = 0;
  int bad   = 0;

  int m_mode [2];
  int m_k    [2];
  int m_stop [2];

  logic [24:0] q0 [$];
  logic [24:0] q1 [$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    simple_ctrl_seq #(.MEM_WAIT(g == 0 ? 0 : 2), .PHASE_W(5)) u_dut (
      .clock             (clock),
      .reset             (reset),
      .exec              (exec),
      .instruction       (instruction),
      .SZCV              (SZCV),
      .phase             (act_w[g][24:20]),
      .running           (act_w[g][19]),
      .halted            (act_w[g][18]),
      .updateInstruction (act_w[g][17]),
      .updateSZCV        (act_w[g][16]),
      .updatePC          (act_w[g][15]),
      .addressSrc        (act_w[g][14]),
      .regDst            (act_w[g][13]),
      .ALUSrcAR          (act_w[g][12]),
      .ALUSrcBR          (act_w[g][11]),
      .DRSrc             (act_w[g][10]),
      .outputEnable      (act_w[g][9]),
      .inputEnable       (act_w[g][8]),
      .memWrite          (act_w[g][7]),
      .branch            (act_w[g][6]),
      .regWrite          (act_w[g][5]),
      .memToReg          (act_w[g][4]),
      .ALUOp             (act_w[g][3:0])
    );
  end

  function automatic int mw_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int kind_of(logic [15:0] ins);
    logic [1:0] c  = ins[15:14];
    logic [3:0] o  = ins[7:4];
    logic [2:0] s  = ins[13:11];
    logic [2:0] cd = ins[10:8];
    if (c == 2'd0) return K_LD;
    if (c == 2'd1) return K_ST;
    if (c == 2'd2) begin
      if (s == 3'd0) return K_LI;
      if (s == 3'd4) return K_B;
      if (s == 3'd7 && cd < 3'd4) return K_BCC;
      return K_UNDEF;
    end
    if (o < 4'd8)   return K_ALU;
    if (o < 4'd12)  return K_SHIFT;
    if (o == 4'd12) return K_IN;
    if (o == 4'd13) return K_OUT;
    if (o == 4'd15) return K_HALT;
    return K_UNDEF;
  endfunction

  function automatic bit taken(logic [15:0] ins, logic [3:0] f);
    int  kd = kind_of(ins);
    bit  s  = f[3];
    bit  z  = f[2];
    bit  v  = f[0];
    int  cd = int'(ins[10:8]);
    if (kd == K_B) return 1'b1;
    if (kd != K_BCC) return 1'b0;
    case (cd)
      0:       return z;
      1:       return s != v;
      2:       return z || (s != v);
      default: return !z;
    endcase
  endfunction

  // Expected outputs from the instruction-cycle index k: P1 covers k=0..mw, P2 and P3 one
  // cycle each, P4 covers the next mw+1 cycles, P5 is the final cycle.
  function automatic logic [24:0] model_out(int mw, int mode, int k, logic [15:0] ins, logic [3:0] f);
    logic [24:0] o;
    int ph;
    bit last;
    int kd;
    bit c11;
    o = '0;
    if (mode == M_HALT) o[18] = 1'b1;
    if (mode != M_RUN) return o;
    kd  = kind_of(ins);
    c11 = (ins[15:14] == 2'b11);
    if (k <= mw) ph = 1;
    else if (k == mw + 1) ph = 2;
    else if (k == mw + 2) ph = 3;
    else if (k <= 2 * mw + 3) ph = 4;
    else ph = 5;
    last = (k == mw) || (k == mw + 1) || (k == mw + 2) || (k == 2 * mw + 3) || (k == 2 * mw + 4);
    o[24:20] = 5'(1 << (ph - 1));
    o[19] = 1'b1;
    o[17] = (ph == 1) && last;
    o[16] = (ph == 3);
    o[15] = (ph == 5);
    o[14] = (ph == 4);
    o[13] = (ph == 2) && (kd == K_LD);
    o[12] = (ph == 3) && c11;
    o[11] = (ph == 3) && (ins[15:14] != 2'b10);
    o[10] = (ph == 3) && c11 && ins[7];
    o[9]  = (ph == 3) && (kd == K_OUT);
    o[8]  = (ph == 4) && (kd == K_IN);
    o[7]  = (ph == 4) && (kd == K_ST);
    o[6]  = (ph == 4) && last && taken(ins, f);
    o[5]  = (ph == 5) && (kd inside {K_ALU, K_SHIFT, K_IN, K_LD, K_LI});
    o[4]  = (ph == 5) && (kd == K_LD || kd == K_IN);
    if (c11) o[3:0] = ins[7:4];
    else if (kd == K_LI) o[3:0] = 4'b0110;
    return o;
  endfunction

  task automatic advance(input int i);
    int len = 2 * mw_of(i) + 5;
    if (reset) begin
      m_mode[i] = M_IDLE;
      m_k[i]    = 0;
      m_stop[i] = 0;
    end else if (m_mode[i] == M_RUN) begin
      if (m_k[i] == len - 1) begin
        if (kind_of(instruction) == K_HALT) begin
          m_mode[i] = M_HALT;
          m_stop[i] = 0;
        end else if (m_stop[i] != 0) begin
          m_mode[i] = M_IDLE;
          m_stop[i] = 0;
        end else begin
          m_k[i] = 0;
          if (exec) m_stop[i] = 1;
        end
      end else begin
        m_k[i] = m_k[i] + 1;
        if (exec) m_stop[i] = 1;
      end
    end else if (exec) begin
      m_mode[i] = M_RUN;
      m_k[i]    = 0;
      m_stop[i] = 0;
    end
  endtask

  task automatic cycle(input logic rst, input logic ex);
    reset = rst;
    exec  = ex;
    q0.push_back(model_out(mw_of(0), m_mode[0], m_k[0], instruction, SZCV));
    q1.push_back(model_out(mw_of(1), m_mode[1], m_k[1], instruction, SZCV));
    advance(0);
    advance(1);
    @(posedge clock);
    #1;
  endtask

  task automatic run_seg(input logic [15:0] ins, input logic [3:0] f);
    instruction = ins;
    SZCV        = f;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
  endtask

  initial begin : monitor
    logic [24:0] want;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (q0.size() > 0) begin
        want = q0.pop_front();
        total++;
        if (act_w[0] !== want) begin
          bad++;
          $display("FAIL outputs_mw0 cyc=%0d got=%h want=%h", cyc, act_w[0], want);
        end
      end
      if (q1.size() > 0) begin
        want = q1.pop_front();
        total++;
        if (act_w[1] !== want) begin
          bad++;
          $display("FAIL outputs_mw2 cyc=%0d got=%h want=%h", cyc, act_w[1], want);
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE;
      m_k[i]    = 0;
      m_stop[i] = 0;
    end
    reset       = 1'b1;
    exec        = 1'b0;
    instruction = 16'h0000;
    SZCV        = 4'h0;
    repeat (2) @(posedge clock);
    #1;

    run_seg(16'hC000, 4'b0000);
    run_seg(16'h4000, 4'b0000);
    run_seg(16'hB800, 4'b0100);
    run_seg(16'hB800, 4'b0000);
    run_seg(16'hB900, 4'b1000);
    run_seg(16'hB900, 4'b1001);
    run_seg(16'hBA00, 4'b0001);
    run_seg(16'hBB00, 4'b0000);
    run_seg(16'hC0E0, 4'b1111);

    // HALT, then restart from HALTED
    instruction = 16'hC0F0;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    // Stop requested early in an LI instruction
    instruction = 16'h8000;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (15) cycle(1'b0, 1'b0);

    // Reset landing mid-instruction on a store
    instruction = 16'h4000;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(9) == 0) begin
        if ($urandom_range(1) == 0) instruction = TABLE[$urandom_range(15)];
        else instruction = 16'($urandom);
      end
      if ($urandom_range(3) == 0) SZCV = 4'($urandom);
      cycle($urandom_range(299) == 0, $urandom_range(11) == 0);
    end

    @(negedge clock);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
